// File: rtl/nand_pkg.sv
// Shared definitions for the small-page NAND flash responder.
// The status-read state exists only when NAND_RESP_STATUS_EN is defined.
package nand_pkg;

  localparam int PAGE_BITS_DEF = 9;
  localparam int COL_BITS_DEF  = 9;

  localparam logic [7:0] CMD_READ0   = 8'h00;
  localparam logic [7:0] CMD_READ1   = 8'h01;
  localparam logic [7:0] CMD_PROG    = 8'h80;
  localparam logic [7:0] CMD_CONFIRM = 8'h10;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_STATUS  = 8'h70;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_BUSY,
    ST_RD_DATA,
    ST_PG_ADDR,
    ST_PG_DATA,
    ST_PG_BUSY,
    ST_RST_BUSY
`ifdef NAND_RESP_STATUS_EN
    ,
    ST_STATUS
`endif
  } nand_state_e;

  // Debug view of the responder for checkers and waveforms.
  typedef struct packed {
    nand_state_e state;
    logic        io_oe;
    logic        pg_full;
    logic        ren_fall;
  } nand_dbg_t;

endpackage

// File: rtl/nand_strobe_det.sv
// Registers the WEN/REN strobes, produces the latch event and REN edge pulses,
// and classifies each latch as command, address or data.
module nand_strobe_det (
  input  logic clk,
  input  logic rst,
  input  logic wen,
  input  logic ren,
  input  logic cle,
  input  logic ale,
  output logic latch_evt,
  output logic cmd_evt,
  output logic addr_evt,
  output logic data_evt,
  output logic ren_rise,
  output logic ren_fall
);

  logic wen_q;
  logic ren_q;

  // Idle strobes are high, so resetting to 1 avoids a spurious edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q <= 1'b1;
      ren_q <= 1'b1;
    end else begin
      wen_q <= wen;
      ren_q <= ren;
    end
  end

  assign latch_evt = wen && !wen_q;
  assign cmd_evt   = latch_evt &&  cle && !ale;
  assign addr_evt  = latch_evt && !cle &&  ale;
  assign data_evt  = latch_evt && !cle && !ale;
  assign ren_rise  = ren && !ren_q;
  assign ren_fall  = !ren && ren_q;

endmodule

// File: rtl/nand_flash_resp.sv
// Small-page NAND flash responder: page read (00h/01h), program (80h..10h), reset (FFh).
// Define NAND_RESP_STATUS_EN to add the 70h status read.
module nand_flash_resp
  import nand_pkg::*;
#(
  parameter int PAGE_BITS = PAGE_BITS_DEF,
  parameter int COL_BITS  = COL_BITS_DEF,
  parameter int READ_BUSY = 16,
  parameter int PROG_BUSY = 32,
  parameter int RST_BUSY  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  inout  wire  [7:0]                    F_IO,
  input  logic                          F_CLE,
  input  logic                          F_ALE,
  input  logic                          F_WEN,
  input  logic                          F_REN,
  output logic                          F_RB,
  output logic [PAGE_BITS+COL_BITS-1:0] mem_addr,
  input  logic [7:0]                    mem_rdata,
  output logic [7:0]                    mem_wdata,
  output logic                          mem_we,
  output nand_dbg_t                     dbg
);

  localparam int CNT_W = 16;
  localparam int AW    = PAGE_BITS + COL_BITS;

  // Handshake: a byte moves on the clock where F_WEN is seen rising; read data is
  // valid on F_IO while F_REN is low and the next byte is selected on F_REN rising.
  logic latch_evt, cmd_evt, addr_evt, data_evt, ren_rise, ren_fall;

  nand_strobe_det u_strobe (
    .clk       (clk),
    .rst       (rst),
    .wen       (F_WEN),
    .ren       (F_REN),
    .cle       (F_CLE),
    .ale       (F_ALE),
    .latch_evt (latch_evt),
    .cmd_evt   (cmd_evt),
    .addr_evt  (addr_evt),
    .data_evt  (data_evt),
    .ren_rise  (ren_rise),
    .ren_fall  (ren_fall)
  );

  nand_state_e          state_q, state_d;
  logic [PAGE_BITS-1:0] page_q, page_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic [COL_BITS-1:0]  col_base_q, col_base_d;
  logic [1:0]           addr_cnt_q, addr_cnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rb_q, rb_d;
  logic                 we_q, we_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [AW-1:0]        waddr_q, waddr_d;
  logic                 full_q, full_d;
  logic [7:0]           io_in;
  logic [7:0]           io_out;
  logic                 io_oe;

  assign io_in = F_IO;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      page_q     <= '0;
      col_q      <= '0;
      col_base_q <= '0;
      addr_cnt_q <= '0;
      cnt_q      <= '0;
      rb_q       <= 1'b1;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      col_q      <= col_d;
      col_base_q <= col_base_d;
      addr_cnt_q <= addr_cnt_d;
      cnt_q      <= cnt_d;
      rb_q       <= rb_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      full_q     <= full_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    col_d      = col_q;
    col_base_d = col_base_q;
    addr_cnt_d = addr_cnt_q;
    cnt_d      = cnt_q;
    rb_d       = rb_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    waddr_d    = waddr_q;
    full_d     = full_q;

    // The busy countdown runs independently of state so a status read can sit on top of it.
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        rb_d = 1'b1;
        case (state_q)
          ST_RD_BUSY:              state_d = ST_RD_DATA;
          ST_PG_BUSY, ST_RST_BUSY: state_d = ST_IDLE;
          default: ;
        endcase
      end
    end

    if (ren_rise && rb_q && state_q == ST_RD_DATA) col_d = col_q + COL_BITS'(1);

    if (cmd_evt) begin
      if (io_in == CMD_RESET) begin
        state_d    = ST_RST_BUSY;
        rb_d       = 1'b0;
        cnt_d      = CNT_W'(RST_BUSY);
        addr_cnt_d = '0;
`ifdef NAND_RESP_STATUS_EN
      end else if (io_in == CMD_STATUS) begin
        state_d = ST_STATUS;
`endif
      end else if (rb_q) begin
        case (io_in)
          CMD_READ0: begin
            col_base_d = '0;
            addr_cnt_d = '0;
            state_d    = ST_RD_ADDR;
          end
          CMD_READ1: begin
            col_base_d = COL_BITS'(256);
            addr_cnt_d = '0;
            state_d    = ST_RD_ADDR;
          end
          CMD_PROG: begin
            col_base_d = '0;
            addr_cnt_d = '0;
            state_d    = ST_PG_ADDR;
          end
          CMD_CONFIRM: begin
            if (state_q == ST_PG_DATA) begin
              state_d = ST_PG_BUSY;
              rb_d    = 1'b0;
              cnt_d   = CNT_W'(PROG_BUSY);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (addr_evt && rb_q && (state_q == ST_RD_ADDR || state_q == ST_PG_ADDR)) begin
      case (addr_cnt_q)
        2'd0:    col_d = col_base_q + COL_BITS'(io_in);
        2'd1:    page_d[7:0] = io_in;
        default: page_d[PAGE_BITS-1:8] = io_in[PAGE_BITS-9:0];
      endcase
      if (addr_cnt_q == 2'd2) begin
        addr_cnt_d = '0;
        if (state_q == ST_RD_ADDR) begin
          state_d = ST_RD_BUSY;
          rb_d    = 1'b0;
          cnt_d   = CNT_W'(READ_BUSY);
        end else begin
          state_d = ST_PG_DATA;
          full_d  = 1'b0;
        end
      end else begin
        addr_cnt_d = addr_cnt_q + 2'd1;
      end
    end else if (data_evt && rb_q && state_q == ST_PG_DATA && !full_q) begin
      we_d    = 1'b1;
      wdata_d = io_in;
      waddr_d = {page_q, col_q};
      col_d   = col_q + COL_BITS'(1);
      if (col_q == '1) full_d = 1'b1;
    end
  end

  // Never drive the bus on a cycle where the host is handing us a byte.
  always_comb begin
    io_oe  = 1'b0;
    io_out = mem_rdata;
    if (!F_REN && !latch_evt) begin
      if (state_q == ST_RD_DATA && rb_q) io_oe = 1'b1;
`ifdef NAND_RESP_STATUS_EN
      if (state_q == ST_STATUS) begin
        io_oe  = 1'b1;
        io_out = {rb_q, 1'b1, 6'b0};
      end
`endif
    end
  end

  assign F_IO      = io_oe ? io_out : 8'hzz;
  assign F_RB      = rb_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_addr  = we_q ? waddr_q : {page_q, col_q};

  assign dbg.state    = state_q;
  assign dbg.io_oe    = io_oe;
  assign dbg.pg_full  = full_q;
  assign dbg.ren_fall = ren_fall;

endmodule

// File: tb/tb_nand_flash_resp.sv
// Bench for nand_flash_resp: behavioural backing array, read-byte and write scoreboards.
module tb_nand_flash_resp;
  import nand_pkg::*;

  localparam int PAGE_BITS = 9;
  localparam int COL_BITS  = 9;
  localparam int READ_BUSY = 16;
  localparam int PROG_BUSY = 32;
  localparam int RST_BUSY  = 4;
  localparam int AW        = PAGE_BITS + COL_BITS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  wire  [7:0]    f_io;
  logic [7:0]    io_drv = '0;
  logic          io_en = 1'b0;
  logic          F_CLE = 1'b0, F_ALE = 1'b0, F_WEN = 1'b1, F_REN = 1'b1;
  logic          F_RB;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata, mem_wdata;
  logic          mem_we;
  nand_dbg_t     dbg;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [7:0]    pre_d = '0;

  logic [7:0]    exp_q[$];
  logic [AW+7:0] wr_exp_q[$];
  int            n_chk = 0;
  int            n_bad = 0;
  int            n_wr  = 0;

  assign f_io = io_en ? io_drv : 8'hzz;
  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pre_we) mem[pre_a] <= pre_d;
  end

  nand_flash_resp #(
    .PAGE_BITS (PAGE_BITS),
    .COL_BITS  (COL_BITS),
    .READ_BUSY (READ_BUSY),
    .PROG_BUSY (PROG_BUSY),
    .RST_BUSY  (RST_BUSY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .F_IO      (f_io),
    .F_CLE     (F_CLE),
    .F_ALE     (F_ALE),
    .F_WEN     (F_WEN),
    .F_REN     (F_REN),
    .F_RB      (F_RB),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .dbg       (dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write scoreboard: every strobe must match the oldest expected {addr,data}.
  always @(negedge clk) begin
    if (rst && mem_we) begin
      n_wr++;
      check("wr_expected", wr_exp_q.size() != 0, 1);
      if (wr_exp_q.size() != 0) check("wr_addr_data", {mem_addr, mem_wdata}, wr_exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic latch(input logic cle, input logic ale, input logic [7:0] b);
    F_WEN = 1'b0;
    step();
    F_CLE = cle;
    F_ALE = ale;
    io_drv = b;
    io_en = 1'b1;
    F_WEN = 1'b1;
    step();
    F_CLE = 1'b0;
    F_ALE = 1'b0;
    io_en = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] b);  latch(1'b1, 1'b0, b); endtask
  task automatic addr(input logic [7:0] b); latch(1'b0, 1'b1, b); endtask
  task automatic data(input logic [7:0] b); latch(1'b0, 1'b0, b); endtask

  task automatic read_byte(input string tag);
    F_REN = 1'b0;
    #2;
    check({tag, "_oe"}, dbg.io_oe, 1);
    if (exp_q.size() != 0) check(tag, f_io, exp_q.pop_front());
    else check({tag, "_exp_left"}, 0, 1);
    step();
    F_REN = 1'b1;
    step();
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    check({tag, "_low"}, F_RB, 0);
    while (!F_RB && n < 200) begin
      step();
      n++;
    end
    check(tag, n, exp_n);
  endtask

  task automatic preload(input int page, input int col, input logic [7:0] b);
    pre_we = 1'b1;
    pre_a = {page[PAGE_BITS-1:0], col[COL_BITS-1:0]};
    pre_d = b;
    step();
    pre_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         n;

    // Reset and preload page 3 with byte = col[7:0]
    rst = 1'b0;
    for (int c = 0; c < (1 << COL_BITS); c++) preload(3, c, c[7:0]);
    rst = 1'b1;
    step();
    check("rst_rb", F_RB, 1);
    check("rst_we", mem_we, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_state", dbg.state, ST_IDLE);

    // Reset asserted mid read-busy aborts
    cmd(CMD_READ0); addr(8'h00); addr(8'h03); addr(8'h00);
    check("t1_busy", F_RB, 0);
    step(); step(); step();
    rst = 1'b0;
    F_REN = 1'b0;
    #1;
    check("t1_rb_async", F_RB, 1);
    step();
    check("t1_rb", F_RB, 1);
    check("t1_oe", dbg.io_oe, 0);
    check("t1_we", mem_we, 0);
    step();
    F_REN = 1'b1;
    rst = 1'b1;
    step();
    check("t1_state", dbg.state, ST_IDLE);
    check("t1_rb_after", F_RB, 1);

    // Full-page read of page 3 with column wrap
    cmd(CMD_READ0); addr(8'h00); addr(8'h03); addr(8'h00);
    wait_ready("t2_rd_busy", READ_BUSY);
    check("t2_state", dbg.state, ST_RD_DATA);
    for (int c = 0; c <= (1 << COL_BITS); c++) exp_q.push_back(c[7:0]);
    for (int c = 0; c <= (1 << COL_BITS); c++) read_byte("t2_rd");

    // Second-half read starts at column 256+10h of page 5
    for (int c = 272; c < 276; c++) begin
      b = 8'($urandom_range(0, 255));
      preload(5, c, b);
      exp_q.push_back(b);
    end
    cmd(CMD_READ1); addr(8'h10); addr(8'h05); addr(8'h00);
    wait_ready("t3_rd_busy", READ_BUSY);
    check("t3_addr", mem_addr, {9'd5, 9'd272});
    for (int i = 0; i < 4; i++) read_byte("t3_rd");

    // Program page 511 with A5h^col; one extra byte past the wrap is dropped
    cmd(CMD_PROG); addr(8'h00); addr(8'hFF); addr(8'h01);
    check("t4_state", dbg.state, ST_PG_DATA);
    check("t4_rb", F_RB, 1);
    for (int c = 0; c < (1 << COL_BITS); c++) begin
      b = 8'hA5 ^ c[7:0];
      wr_exp_q.push_back({9'd511, c[8:0], b});
      data(b);
    end
    data(8'h33);
    step(); step();
    check("t4_wr_left", wr_exp_q.size(), 0);
    check("t4_wr_count", n_wr, 1 << COL_BITS);
    cmd(CMD_CONFIRM);
    wait_ready("t4_pg_busy", PROG_BUSY);
    check("t4_idle", dbg.state, ST_IDLE);
    cmd(CMD_READ0); addr(8'h00); addr(8'hFF); addr(8'h01);
    wait_ready("t4_rd_busy", READ_BUSY);
    for (int c = 0; c < 4; c++) exp_q.push_back(8'hA5 ^ c[7:0]);
    for (int c = 0; c < 4; c++) read_byte("t4_readback");

    // FFh during program busy; a stray 10h afterwards is ignored
    cmd(CMD_PROG); addr(8'h00); addr(8'h07); addr(8'h00);
    wr_exp_q.push_back({9'd7, 9'd0, 8'h11}); data(8'h11);
    wr_exp_q.push_back({9'd7, 9'd1, 8'h22}); data(8'h22);
    cmd(CMD_CONFIRM);
    step(); step(); step();
    check("t5_pg_busy", dbg.state, ST_PG_BUSY);
    cmd(CMD_RESET);
    wait_ready("t5_rst_busy", RST_BUSY);
    check("t5_idle", dbg.state, ST_IDLE);
    cmd(CMD_CONFIRM);
    step(); step(); step();
    check("t5_confirm_ign_state", dbg.state, ST_IDLE);
    check("t5_confirm_ign_rb", F_RB, 1);

`ifdef NAND_RESP_STATUS_EN
    // Status read during and after read busy
    cmd(CMD_READ0); addr(8'h00); addr(8'h03); addr(8'h00);
    cmd(CMD_STATUS);
    F_REN = 1'b0;
    #2;
    check("t6_status_busy", f_io, 8'h40);
    F_REN = 1'b1;
    n = 0;
    while (!F_RB && n < 200) begin
      step();
      n++;
    end
    check("t6_ready", F_RB, 1);
    check("t6_state", dbg.state, ST_STATUS);
    cmd(CMD_STATUS);
    F_REN = 1'b0;
    #2;
    check("t6_status_ready", f_io, 8'hC0);
    F_REN = 1'b1;
    step();
    cmd(CMD_RESET);
    wait_ready("t6_rst_busy", RST_BUSY);
`else
    // 70h is an unknown command: back to IDLE and the bus stays released
    cmd(CMD_READ0);
    cmd(CMD_STATUS);
    check("t6_unknown_state", dbg.state, ST_IDLE);
    F_REN = 1'b0;
    #2;
    check("t6_unknown_oe", dbg.io_oe, 0);
    F_REN = 1'b1;
    step();
`endif

    check("end_exp_left", exp_q.size(), 0);
    check("end_wr_left", wr_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
